// File: rtl/full_subtractor_reg.sv
// Registered ripple-borrow full subtractor: {b_out, d} = a - b - b_in, one-cycle latency.
// Optional signed-overflow flag output `ovf` is enabled by defining FS_OVERFLOW_EN.
module full_subtractor_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic             b_out
`ifdef FS_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] diff;

    // Borrow ripples LSB first; br[WIDTH] is the borrow out of the MSB cell.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        br    = '0;
        diff  = '0;
        br[0] = b_in;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i]  = a[i] ^ b[i] ^ br[i];
            br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous and
    // takes priority over in_valid on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            d         <= '0;
            b_out     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Result registers only load on valid, so idle-cycle X inputs never reach d/b_out.
            if (in_valid) begin
                d     <= diff;
                b_out <= br[WIDTH];
            end
        end
    end

`ifdef FS_OVERFLOW_EN
    logic ovf_next;

    // Signed overflow: operand signs differ and the result sign differs from the minuend.
    always_comb begin
        ovf_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_full_subtractor_reg.sv
// Scoreboard bench for full_subtractor_reg: a WIDTH=1 and a WIDTH=8 instance side by side.
// Expected results are hand-computed and queued at issue time; negedge monitors pop and compare.
module tb_full_subtractor_reg;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v1, a1, b1, bi1;
    logic       ov1, d1, bo1;
    logic       v8, bi8;
    logic [7:0] a8, b8;
    logic       ov8, bo8;
    logic [7:0] d8;
`ifdef FS_OVERFLOW_EN
    logic       ovf1, ovf8;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t q1[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    full_subtractor_reg #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .b_in(bi1),
        .out_valid(ov1), .d(d1), .b_out(bo1)
`ifdef FS_OVERFLOW_EN
        , .ovf(ovf1)
`endif
    );

    full_subtractor_reg #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .b_in(bi8),
        .out_valid(ov8), .d(d8), .b_out(bo8)
`ifdef FS_OVERFLOW_EN
        , .ovf(ovf8)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one WIDTH=1 vector for the next edge; a result is expected only if it is valid and not reset.
    task automatic set1(input logic v, input logic a, input logic b, input logic bi,
                        input logic ed, input logic ebo, input logic eovf);
        exp_t e;
        v1 = v; a1 = a; b1 = b; bi1 = bi;
        if (v && rst_n) begin
            e.d = {7'd0, ed}; e.bo = ebo; e.ovf = eovf;
            q1.push_back(e);
        end
    endtask

    task automatic set8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic ebo, input logic eovf);
        exp_t e;
        v8 = v; a8 = a; b8 = b; bi8 = bi;
        if (v && rst_n) begin
            e.d = ed; e.bo = ebo; e.ovf = eovf;
            q8.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v8 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("w1_unexpected_out_valid", 64'(ov1), 64'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("w1_d", 64'(d1), 64'(e.d[0]));
                check("w1_b_out", 64'(bo1), 64'(e.bo));
`ifdef FS_OVERFLOW_EN
                check("w1_ovf", 64'(ovf1), 64'(e.ovf));
`endif
            end
        end else if (ov1 !== 1'b0) begin
            check("w1_out_valid_known", 64'(ov1), 64'd0);
        end
    end

    always @(negedge clk) begin
        if (ov8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_out_valid", 64'(ov8), 64'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("w8_d", 64'(d8), 64'(e.d));
                check("w8_b_out", 64'(bo8), 64'(e.bo));
`ifdef FS_OVERFLOW_EN
                check("w8_ovf", 64'(ovf8), 64'(e.ovf));
`endif
            end
        end else if (ov8 !== 1'b0) begin
            check("w8_out_valid_known", 64'(ov8), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;

        // Reset state after one edge held in reset.
        tick();
        check("rst_w1_out_valid", 64'(ov1), 64'd0);
        check("rst_w1_d", 64'(d1), 64'd0);
        check("rst_w1_b_out", 64'(bo1), 64'd0);
        check("rst_w8_out_valid", 64'(ov8), 64'd0);
        check("rst_w8_d", 64'(d8), 64'd0);
        rst_n = 1'b1;
        tick();

        // WIDTH=1 exhaustive, one per cycle: (a,b,b_in) -> d, b_out, ovf.
        set1(1, 0, 0, 0, 0, 0, 0); tick();
        set1(1, 0, 0, 1, 1, 1, 0); tick();
        set1(1, 0, 1, 0, 1, 1, 1); tick();
        set1(1, 0, 1, 1, 0, 1, 0); tick();
        set1(1, 1, 0, 0, 1, 0, 0); tick();
        set1(1, 1, 0, 1, 0, 0, 1); tick();
        set1(1, 1, 1, 0, 0, 0, 0); tick();
        set1(1, 1, 1, 1, 1, 1, 0); tick();

        // Reset overrides in_valid for two edges, including the cycle after the last vector.
        set1(1, 0, 1, 1, 0, 1, 0); tick();
        rst_n = 1'b0;
        set1(1, 1, 0, 0, 1, 0, 0); tick();
        check("rst_mid_w1_out_valid", 64'(ov1), 64'd0);
        check("rst_mid_w1_d", 64'(d1), 64'd0);
        check("rst_mid_w1_b_out", 64'(bo1), 64'd0);
        set1(1, 1, 0, 0, 1, 0, 0); tick();
        check("rst_mid2_w1_out_valid", 64'(ov1), 64'd0);
        check("rst_mid2_w1_d", 64'(d1), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_no_stale_valid", 64'(ov1), 64'd0);
        set1(1, 1, 0, 0, 1, 0, 0); tick();

        // Hold: invalid cycles keep d/b_out, including with X operands.
        set1(1, 0, 1, 0, 1, 1, 1); tick();
        set1(0, 1, 1, 1, 0, 0, 0); tick();
        check("hold_w1_out_valid", 64'(ov1), 64'd0);
        check("hold_w1_d", 64'(d1), 64'd1);
        check("hold_w1_b_out", 64'(bo1), 64'd1);
`ifdef FS_OVERFLOW_EN
        check("hold_w1_ovf", 64'(ovf1), 64'd1);
`endif
        set1(0, 1'bx, 1'bx, 1'bx, 0, 0, 0); tick();
        check("xhold_w1_d", 64'(d1), 64'd1);
        check("xhold_w1_b_out", 64'(bo1), 64'd1);

        // WIDTH=8 ripple corner cases.
        set8(1, 8'h00, 8'h01, 0, 8'hFF, 1, 0); tick();
        set8(1, 8'h80, 8'h7F, 1, 8'h00, 0, 1); tick();
        set8(1, 8'h10, 8'h10, 1, 8'hFF, 1, 0); tick();
        set8(1, 8'hFF, 8'h00, 0, 8'hFF, 0, 0); tick();
        set8(0, 8'hxx, 8'hxx, 1'bx, 8'h00, 0, 0); tick();
        check("xhold_w8_d", 64'(d8), 64'hFF);
        check("xhold_w8_b_out", 64'(bo8), 64'd0);

        // Throughput: four back-to-back vectors, results in order, mod 512.
        set8(1, 8'h55, 8'h22, 0, 8'h33, 0, 0); tick();
        set8(1, 8'h01, 8'h02, 1, 8'hFE, 1, 0); tick();
        set8(1, 8'hFF, 8'hFF, 1, 8'hFF, 1, 0); tick();
        set8(1, 8'hA0, 8'h0F, 0, 8'h91, 0, 0); tick();

        // Signed-overflow vectors (d/b_out are checked in every build).
        set8(1, 8'h80, 8'h01, 0, 8'h7F, 0, 1); tick();
        set8(1, 8'h05, 8'h03, 0, 8'h02, 0, 0); tick();
        set8(1, 8'h7F, 8'hFF, 0, 8'h80, 1, 1); tick();

        // Drain: every queued expectation must have been consumed.
        repeat (4) tick();
        check("w1_queue_drained", 64'(q1.size()), 64'd0);
        check("w8_queue_drained", 64'(q8.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
